decoder_seq: RTL and testbench

//  Parametrised instruction sequencer for the bb_core control path. Fetches an

---
 rtl/decoder_seq.sv | 144 ++++++++++++++
 tb/tb_decoder_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// Instruction sequencer for the bb_core control path: fetch, decode, then a
// memory handshake with one-hot unit enables, wait-state timeout and PAUSE.
module decoder_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int UNIT_W     = 6,
    parameter int N_UNITS    = 6,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_ir,
    input  logic                  i_mem_ready,
    input  logic                  i_resume,
    output logic                  o_mem_req,
    output logic [1:0]            o_mem_action,
    output logic                  o_mem_addr_source,
    output logic                  o_pc_counter_en,
    output logic [N_UNITS-1:0]    o_unit_reg_input_en,
    output logic [N_UNITS-1:0]    o_unit_reg_output_en,
    output logic [N_UNITS-1:0]    o_unit_alu_output_en,
    output logic                  o_timeout_err,
    output logic [2:0]            o_state
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_PAUSE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         act_q, act_d;
    logic [UNIT_W-1:0]  u_q, u_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [31:0]        u_ext;
    logic [N_UNITS-1:0] reg_hot;
    logic [N_UNITS-1:0] alu_hot;
    logic               in_req;
    logic               wait_expired;

    assign u_ext   = 32'(u_q);
    assign reg_hot = (u_ext < 32'(N_UNITS)) ? (N_UNITS'(1) << u_ext) : '0;
    assign alu_hot = ((u_ext >= 32'(N_UNITS)) && (u_ext < 32'(2 * N_UNITS)))
                     ? (N_UNITS'(1) << (u_ext - 32'(N_UNITS))) : '0;

    assign in_req       = (state_q == S_FETCH) || (state_q == S_READ) || (state_q == S_WRITE);
    // Expiry only when this is the TIMEOUT-th ready-low cycle; ready in that cycle still completes.
    assign wait_expired = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));

    // Handshake: req/action/addr_src/output enables are held for the whole wait;
    // the access completes in the cycle i_mem_ready=1, and input_en/pc_en pulse only then.
    always_comb begin
        state_d              = state_q;
        act_d                = act_q;
        u_d                  = u_q;
        cnt_d                = '0;
        err_d                = err_q;
        o_mem_req            = 1'b0;
        o_mem_action         = 2'b00;
        o_mem_addr_source    = 1'b0;
        o_pc_counter_en      = 1'b0;
        o_unit_reg_input_en  = '0;
        o_unit_reg_output_en = '0;
        o_unit_alu_output_en = '0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                o_mem_req    = 1'b1;
                o_mem_action = 2'b01;
                if (i_mem_ready) begin
                    o_pc_counter_en     = 1'b1;
                    o_unit_reg_input_en = N_UNITS'(1);
                    state_d             = S_DECODE;
                end
            end
            S_DECODE: begin
                act_d = i_ir[DATA_WIDTH-1 -: 2];
                u_d   = i_ir[UNIT_W-1:0];
                case (i_ir[DATA_WIDTH-1 -: 2])
                    2'b00, 2'b01: state_d = S_READ;
                    2'b10:        state_d = S_WRITE;
                    default:      state_d = S_PAUSE;
                endcase
            end
            S_READ: begin
                o_mem_req         = 1'b1;
                o_mem_action      = 2'b01;
                o_mem_addr_source = (act_q == 2'b01);
                if (i_mem_ready) begin
                    o_pc_counter_en     = (act_q == 2'b00);
                    o_unit_reg_input_en = reg_hot;
                    state_d             = S_FETCH;
                end
            end
            S_WRITE: begin
                o_mem_req            = 1'b1;
                o_mem_action         = 2'b10;
                o_mem_addr_source    = 1'b1;
                o_unit_reg_output_en = reg_hot;
                o_unit_alu_output_en = alu_hot;
                if (i_mem_ready) state_d = S_FETCH;
            end
            S_PAUSE: if (i_resume) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        if (in_req && !i_mem_ready) begin
            if (wait_expired) begin
                err_d   = 1'b1;
                state_d = S_PAUSE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            u_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            u_q     <= u_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_timeout_err = err_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq: directed scenarios plus a randomized
// instruction stream checked cycle by cycle against a transaction-level model.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir = '0;
    logic       ready = 1'b0;
    logic       resume = 1'b0;

    logic       mem_req, pc_en, addr_src, err;
    logic [1:0] mem_action;
    logic [5:0] in_en, rout_en, aout_en;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    logic m_err = 1'b0;

    decoder_seq dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_ir                 (ir),
        .i_mem_ready          (ready),
        .i_resume             (resume),
        .o_mem_req            (mem_req),
        .o_mem_action         (mem_action),
        .o_mem_addr_source    (addr_src),
        .o_pc_counter_en      (pc_en),
        .o_unit_reg_input_en  (in_en),
        .o_unit_reg_output_en (rout_en),
        .o_unit_alu_output_en (aout_en),
        .o_timeout_err        (err),
        .o_state              (state)
    );

    always #5 clk = ~clk;

    // Observed bundle: {state, req, action, addr_src, pc_en, in_en, rout_en, aout_en, err}
    logic [26:0] obs;
    assign obs = {state, mem_req, mem_action, addr_src, pc_en, in_en, rout_en, aout_en, err};

    function automatic logic [26:0] pk(logic [2:0] st, logic rq, logic [1:0] ac, logic sr,
                                       logic pc, logic [5:0] ie, logic [5:0] ro,
                                       logic [5:0] ao, logic er);
        return {st, rq, ac, sr, pc, ie, ro, ao, er};
    endfunction

    function automatic logic [5:0] hot(int k);
        logic [5:0] one = 6'd1;
        if (k >= 0 && k < 6) return one << k;
        return 6'd0;
    endfunction

    task automatic test_reset();
        logic [26:0] ex;
        rst = 1'b1; ready = 1'b1; resume = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        ex = pk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== ex) begin n_bad++; $display("FAIL reset_held: got %h expected %h", obs, ex); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++;
        if (obs !== ex) begin n_bad++; $display("FAIL reset_idle: got %h expected %h", obs, ex); end
        m_err = 1'b0;
    endtask

    // One instruction from the FETCH state: fd/od ready-low cycles before
    // completion, pl resume-low cycles in PAUSE.
    task automatic run_instr(input logic [7:0] ir_v, input int fd, input int od, input int pl);
        logic [26:0] ex;
        logic [1:0] act;
        int u;
        act = ir_v[7:6];
        u = int'(ir_v[5:0]);
        for (int i = 0; i <= fd; i++) begin
            @(negedge clk); ir = 8'($urandom); ready = (i == fd); resume = 1'b0; #1;
            ex = pk(1, 1, 2'b01, 0, ready, ready ? 6'd1 : 6'd0, 0, 0, m_err);
            n_cmp++;
            if (obs !== ex) begin n_bad++; $display("FAIL fetch ir=%h cyc=%0d: got %h expected %h", ir_v, i, obs, ex); end
        end
        @(negedge clk); ir = ir_v; ready = 1'($urandom); #1;
        ex = pk(2, 0, 0, 0, 0, 0, 0, 0, m_err);
        n_cmp++;
        if (obs !== ex) begin n_bad++; $display("FAIL decode ir=%h: got %h expected %h", ir_v, obs, ex); end
        if (act == 2'b11) begin
            for (int i = 0; i <= pl; i++) begin
                @(negedge clk); ir = 8'($urandom); ready = 1'($urandom); resume = (i == pl); #1;
                ex = pk(5, 0, 0, 0, 0, 0, 0, 0, m_err);
                n_cmp++;
                if (obs !== ex) begin n_bad++; $display("FAIL pause ir=%h cyc=%0d: got %h expected %h", ir_v, i, obs, ex); end
            end
        end else begin
            for (int i = 0; i <= od; i++) begin
                @(negedge clk); ir = 8'($urandom); ready = (i == od); #1;
                ex = pk((act == 2'b10) ? 3'd4 : 3'd3, 1, (act == 2'b10) ? 2'b10 : 2'b01,
                        act != 2'b00, (act == 2'b00) && ready,
                        (act != 2'b10 && ready) ? hot(u) : 6'd0,
                        (act == 2'b10) ? hot(u) : 6'd0,
                        (act == 2'b10) ? hot(u - 6) : 6'd0, m_err);
                n_cmp++;
                if (obs !== ex) begin n_bad++; $display("FAIL access ir=%h cyc=%0d: got %h expected %h", ir_v, i, obs, ex); end
            end
        end
    endtask

    task automatic test_directed();
        run_instr(8'h82, 0, 0, 0);
        run_instr(8'h49, 0, 0, 0);
        run_instr(8'h89, 0, 0, 0);
        run_instr(8'h01, 0, 4, 0);
        run_instr(8'hC0, 0, 0, 10);
        run_instr(8'h8A, 14, 14, 0);
        run_instr(8'h05, 14, 14, 0);
    endtask

    task automatic test_timeout();
        logic [26:0] ex;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); ir = 8'($urandom); ready = 1'b0; resume = 1'b0; #1;
            ex = pk(1, 1, 2'b01, 0, 0, 0, 0, 0, m_err);
            n_cmp++;
            if (obs !== ex) begin n_bad++; $display("FAIL timeout_wait cyc=%0d: got %h expected %h", i, obs, ex); end
        end
        m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ready = 1'($urandom); resume = (i == 3); #1;
            ex = pk(5, 0, 0, 0, 0, 0, 0, 0, 1);
            n_cmp++;
            if (obs !== ex) begin n_bad++; $display("FAIL timeout_pause cyc=%0d: got %h expected %h", i, obs, ex); end
        end
        run_instr(8'h82, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] ir_v;
        for (int n = 0; n < 40; n++) begin
            ir_v = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 15))};
            run_instr(ir_v, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
        end
    endtask

    task automatic test_reset_mid();
        logic [26:0] ex;
        @(negedge clk); ready = 1'b1; resume = 1'b0; #1;
        ex = pk(1, 1, 2'b01, 0, 1, 6'd1, 0, 0, m_err);
        n_cmp++;
        if (obs !== ex) begin n_bad++; $display("FAIL rstmid_fetch: got %h expected %h", obs, ex); end
        @(negedge clk); ir = 8'h82; #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ir = 8'($urandom); ready = 1'b0; #1;
            ex = pk(4, 1, 2'b10, 1, 0, 0, 6'b000100, 0, m_err);
            n_cmp++;
            if (obs !== ex) begin n_bad++; $display("FAIL rstmid_write cyc=%0d: got %h expected %h", i, obs, ex); end
        end
        @(negedge clk); rst = 1'b1; resume = 1'b1;
        @(negedge clk); #1;
        m_err = 1'b0;
        ex = pk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== ex) begin n_bad++; $display("FAIL rstmid_abandon: got %h expected %h", obs, ex); end
        rst = 1'b0; resume = 1'b0;
        run_instr(8'h03, 1, 2, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
